// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds,
// sticky overflow/underflow flags and registered or fall-through read.
module sync_fifo_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  output logic                  w_almost_full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_CNT = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign w_full         = (count == FULL_CNT);
  assign r_empty        = (count == '0);
  assign w_almost_full  = (count >= AF_CNT);
  assign r_almost_empty = (count <= AE_CNT);

  // Full/empty gating resolves simultaneous requests at the boundaries.
  assign do_push = push && !w_full;
  assign do_pop  = pop && !r_empty;

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A new error event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (push && w_full) || (overflow && !err_clr);
      underflow <= (pop && r_empty) || (underflow && !err_clr);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign r_data  = r_empty ? '0 : mem[rd_ptr];
      assign r_valid = !r_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rvalid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= do_pop;
          if (do_pop) rdata_q <= mem[rd_ptr];
        end
      end

      assign r_data  = rdata_q;
      assign r_valid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered and fall-through instances
// share stimulus and are checked against a queue-based reference.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] w_data = '0;

  logic       w_full_0, w_af_0, r_valid_0, r_empty_0, r_ae_0, ov_0, un_0;
  logic [7:0] r_data_0;
  logic [3:0] count_0;
  logic       w_full_1, w_af_1, r_valid_1, r_empty_1, r_ae_1, ov_1, un_1;
  logic [7:0] r_data_1;
  logic [3:0] count_1;

  int errs = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;
  logic       m_rv = 1'b0;
  logic [7:0] m_rd = '0;

  always #5 clk = ~clk;

  sync_fifo_param #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AF_LEVEL(6),
                    .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .push(push), .w_data(w_data),
    .w_full(w_full_0), .w_almost_full(w_af_0), .pop(pop),
    .r_data(r_data_0), .r_valid(r_valid_0), .r_empty(r_empty_0),
    .r_almost_empty(r_ae_0), .count(count_0), .overflow(ov_0),
    .underflow(un_0), .err_clr(err_clr)
  );

  sync_fifo_param #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AF_LEVEL(6),
                    .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .push(push), .w_data(w_data),
    .w_full(w_full_1), .w_almost_full(w_af_1), .pop(pop),
    .r_data(r_data_1), .r_valid(r_valid_1), .r_empty(r_empty_1),
    .r_almost_empty(r_ae_1), .count(count_1), .overflow(ov_1),
    .underflow(un_1), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p, input logic [7:0] d, input logic pp,
                      input logic ec, input logic r);
    int n;
    push = p; w_data = d; pop = pp; err_clr = ec; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0; m_rd = '0;
    end else begin
      n = q.size();
      m_ov = (p && n == 8) || (m_ov && !ec);
      m_un = (pp && n == 0) || (m_un && !ec);
      m_rv = pp && n != 0;
      if (m_rv) m_rd = q.pop_front();
      if (p && n != 8) q.push_back(d);
    end
    #1;
    n = q.size();
    check("count", count_0, n);
    check("r_empty", r_empty_0, n == 0);
    check("r_almost_empty", r_ae_0, n <= 2);
    check("w_full", w_full_0, n == 8);
    check("w_almost_full", w_af_0, n >= 6);
    check("overflow", ov_0, m_ov);
    check("underflow", un_0, m_un);
    check("r_valid_reg", r_valid_0, m_rv);
    check("r_data_reg", r_data_0, m_rd);
    check("count_fwft", count_1, n);
    check("overflow_fwft", ov_1, m_ov);
    check("underflow_fwft", un_1, m_un);
    check("r_valid_fwft", r_valid_1, n != 0);
    if (n != 0) check("r_data_fwft", r_data_1, q[0]);
  endtask

  initial begin
    // reset
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    // fill 1..8, overflow attempt, drain
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    // underflow, clear, clear racing a new overflow
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    step(1, 8'hAB, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    // simultaneous push/pop when full, then when empty
    step(1, 8'hCC, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'h77, 1, 0, 0);
    // simultaneous at count 4
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    // continuous streaming across pointer wrap
    for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 0, 0);
    for (int i = 3; i < 20; i++) step(1, 8'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    // mid-run reset with count 5, with requests in the reset cycle
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(1, 8'hEE, 1, 0, 1);
    step(1, 8'h55, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 99) < 2));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
